mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum bus wait cycles before a transaction is aborted.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-004 in_valid  input  1  an instruction is presented from the execute register this cycle.
REQ-005 MemRead  input  1  the presented instruction is a load.
REQ-006 MemWr  input  1  the presented instruction is a store.
REQ-007 funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALU_Out  input  32  effective address, or the result for non-memory instructions.
REQ-009 rd2  input  32  store data.
REQ-010 stall  output  1  upstream holds its register while this is high.
REQ-011 out_valid  output  1  one-cycle pulse: read_data and mem_err are valid for writeback.
REQ-012 read_data  output  32  extended load result, ALU_Out pass-through, or 0.
REQ-013 mem_err  output  1  misaligned access, illegal funct3, MemRead&MemWr, or timeout; qualified by out_valid.
REQ-014 bus_req, bus_we  output  1 each  bus request and write strobe.
REQ-015 bus_addr  output  32  word address {ALU_Out[31:2],2'b00}.
REQ-016 bus_wdata  output  32  lane-replicated store data; bus_be  output  4  byte enables.
REQ-017 bus_ack  input  1  transfer complete; bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-018 The FSM shall have states IDLE and WAIT; stall shall equal (state==WAIT) combinationally.
REQ-019 In IDLE, when in_valid=1 and MemRead=MemWr=0, the unit shall emit out_valid=1, read_data=ALU_Out, mem_err=0 on the next cycle.
REQ-020 In IDLE, when in_valid=1 and an access is legal, the unit shall latch address, data, size and direction, and shall enter WAIT with bus_req=1 on the next cycle.
REQ-021 An access is illegal if MemRead&MemWr, if funct3 is not listed for its direction (BU/HU are load-only), if H has ALU_Out[0]=1, or if W has ALU_Out[1:0]!=0.
REQ-022 An illegal access shall issue no bus request and shall emit out_valid=1, mem_err=1, read_data=0 on the next cycle.
REQ-023 Stores: B shall drive wdata={4{rd2[7:0]}} and be=4'b0001<<addr[1:0]; H shall drive {2{rd2[15:0]}} and 4'b0011<<addr[1:0]; W shall drive rd2 and 4'b1111. bus_we=1.
REQ-024 Loads shall drive bus_we=0 and be equal to the access mask; bus_wdata=0.
REQ-025 bus_req, bus_addr, bus_we, bus_wdata and bus_be shall be registered and stable throughout WAIT.
REQ-026 When bus_ack=1 is sampled in WAIT, the unit shall return to IDLE on the next cycle with bus_req=0, out_valid=1 and mem_err=0.
REQ-027 Load data shall select the byte or half by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU); W shall pass bus_rdata through. Stores shall return read_data=0.
REQ-028 A wait counter shall clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-029 On reaching TIMEOUT, the unit shall abort to IDLE with bus_req=0, out_valid=1, mem_err=1 and read_data=0.
REQ-030 An ack arriving in the same cycle the count reaches TIMEOUT shall count as success.
REQ-031 In WAIT, in_valid shall be ignored; upstream holds its register under stall.
REQ-032 The unit shall accept a new instruction in the first IDLE cycle after completion, giving back-to-back throughput of 1 per cycle for non-memory instructions.
REQ-033 Outside the response cycle, out_valid, mem_err and read_data shall be 0.
REQ-034 bus_ack while in IDLE shall be ignored.

Reset
REQ-035 While n_rst=1, state=IDLE, counter=0, and all outputs (stall, out_valid, read_data, mem_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be) shall be 0 immediately, without waiting for a clock edge.
REQ-036 Reset during WAIT shall abandon the transaction with no out_valid pulse; the first cycle after release shall be IDLE.

Verification
REQ-037 LB at ALU_Out=0x1003, funct3=000, rdata=0x80FF_FF12 -> be=1000 and addr=0x1000; out_valid the cycle after ack with read_data=0xFFFF_FF80.
REQ-038 SH at 0x2002, rd2=0x0000_ABCD, ack after 3 WAIT cycles -> wdata=0xABCD_ABCD, be=1100, stall high exactly 3 cycles, read_data=0.
REQ-039 LW at 0x3001 -> no bus_req; next cycle out_valid=1, mem_err=1, read_data=0.
REQ-040 LHU at 0x4000 with bus_ack never asserted, TIMEOUT=16 -> bus_req high 16 cycles; then out_valid=1, mem_err=1, bus_req=0.
REQ-041 Non-memory instructions with ALU_Out=5, then 6 on consecutive cycles -> out_valid on two consecutive cycles with read_data=5, then 6; stall stays 0.
REQ-042 n_rst pulsed in the 2nd WAIT cycle of a load -> bus_req=0 asynchronously; no out_valid; the next LW at 0x0 completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bus-side signals of the memory access unit: one req/ack transfer per access.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: decodes loads/stores, runs one bus transfer per legal access
// with a timeout, and returns a single-cycle writeback response. Non-memory
// instructions pass ALU_Out through with one cycle of latency.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWr,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU_Out,
    input  logic [31:0] rd2,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] read_data,
    output logic        mem_err,
    mem_access_unit_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state, state_d;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    acc_f3;
    logic [1:0]    acc_lo;

    logic          mem_op, fmt_ok, misaligned, access_ok;
    logic          start, ack_hit, timeout_hit;
    logic [3:0]    lane_mask;
    logic [31:0]   store_data;
    logic [31:0]   lane_word;
    logic [31:0]   load_value;
    logic          resp_valid_d, resp_err_d;
    logic [31:0]   resp_data_d;

    // Decode the presented instruction: legality, base lane mask, store data.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        fmt_ok     = 1'b0;
        misaligned = 1'b0;
        lane_mask  = 4'b0000;
        store_data = '0;
        mem_op     = MemRead | MemWr;
        case (funct3)
            3'b000: begin fmt_ok = 1'b1;    lane_mask = 4'b0001; store_data = {4{rd2[7:0]}};  end
            3'b001: begin fmt_ok = 1'b1;    lane_mask = 4'b0011; store_data = {2{rd2[15:0]}};
                          misaligned = ALU_Out[0]; end
            3'b010: begin fmt_ok = 1'b1;    lane_mask = 4'b1111; store_data = rd2;
                          misaligned = |ALU_Out[1:0]; end
            3'b100: begin fmt_ok = MemRead; lane_mask = 4'b0001; end
            3'b101: begin fmt_ok = MemRead; lane_mask = 4'b0011; misaligned = ALU_Out[0]; end
            default: fmt_ok = 1'b0;
        endcase
        access_ok   = mem_op & ~(MemRead & MemWr) & fmt_ok & ~misaligned;
        start       = (state == ST_IDLE) & in_valid & access_ok;
        ack_hit     = (state == ST_WAIT) & bus.bus_ack;
        // Ack takes priority in the final wait cycle, so a late ack still succeeds.
        timeout_hit = (state == ST_WAIT) & ~bus.bus_ack & (wait_cnt == CW'(TIMEOUT - 1));
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        lane_word  = bus.bus_rdata >> {acc_lo, 3'b000};
        load_value = bus.bus_rdata;
        case (acc_f3)
            3'b000: load_value = {{24{lane_word[7]}},  lane_word[7:0]};
            3'b001: load_value = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100: load_value = {24'h0, lane_word[7:0]};
            3'b101: load_value = {16'h0, lane_word[15:0]};
            default: load_value = bus.bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (n_rst) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next-state logic: leave IDLE only for a legal access, leave WAIT on ack or timeout.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (start)                 state_d = ST_WAIT;
            ST_WAIT: if (ack_hit || timeout_hit) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Output logic: stall, and the writeback response to register for next cycle.
    always_comb begin
        stall        = (state == ST_WAIT);
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_data_d  = '0;
        case (state)
            ST_IDLE: begin
                if (in_valid && !mem_op) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = ALU_Out;
                end else if (in_valid && !access_ok) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.bus_ack) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = bus.bus_we ? 32'h0 : load_value;
                end else if (timeout_hit) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: response, latched bus request and wait counter.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            out_valid     <= 1'b0;
            mem_err       <= 1'b0;
            read_data     <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
            acc_f3        <= '0;
            acc_lo        <= '0;
            wait_cnt      <= '0;
        end else begin
            out_valid <= resp_valid_d;
            mem_err   <= resp_err_d;
            read_data <= resp_data_d;
            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= MemWr;
                bus.bus_addr  <= {ALU_Out[31:2], 2'b00};
                bus.bus_wdata <= MemWr ? store_data : 32'h0;
                bus.bus_be    <= lane_mask << ALU_Out[1:0];
                acc_f3        <= funct3;
                acc_lo        <= ALU_Out[1:0];
                wait_cnt      <= '0;
            end else if (ack_hit || timeout_hit) begin
                bus.bus_req   <= 1'b0;
                bus.bus_we    <= 1'b0;
                bus.bus_addr  <= '0;
                bus.bus_wdata <= '0;
                bus.bus_be    <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a behavioural reference model.
module tb_mem_access_unit;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWr = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] ALU_Out = '0;
    logic [31:0] rd2 = '0;
    logic        stall;
    logic        out_valid;
    logic [31:0] read_data;
    logic        mem_err;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .MemRead   (MemRead),
        .MemWr     (MemWr),
        .funct3    (funct3),
        .ALU_Out   (ALU_Out),
        .rd2       (rd2),
        .stall     (stall),
        .out_valid (out_valid),
        .read_data (read_data),
        .mem_err   (mem_err),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                    input logic [31:0] a);
        int n;
        if (rd && wr) return 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: n = size_bytes(f3);
            3'b100, 3'b101:         n = rd ? size_bytes(f3) : 0;
            default:                n = 0;
        endcase
        if (n == 0) return 1'b0;
        return (int'(a[1:0]) % n) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        longint n, span, v;
        n    = size_bytes(f3);
        span = longint'(1) << (8 * n);
        v    = (longint'(word) >> (8 * int'(a[1:0]))) % span;
        if (!f3[2] && n < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_response: got read_data=%0h mem_err=%0b expected none",
                         read_data, mem_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data", read_data, mon_e.data);
                check("resp_err", mem_err, mon_e.err);
            end
        end
    end

    // ---------------- driver + bus slave ----------------
    // lat = index of the WAIT cycle in which ack is raised; lat >= TIMEOUT means never.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] rdat, input int lat);
        bit          legal, mem, stable_err, quiet_err;
        int          n, cyc;
        logic [31:0] exp_be, exp_wdata;
        logic [69:0] snap;
        exp_t        e;
        mem   = rd || wr;
        legal = is_legal(rd, wr, f3, alu);
        e.err  = 1'b0;
        e.data = '0;
        if (!mem)                 e.data = alu;
        else if (!legal)          e.err  = 1'b1;
        else if (lat >= TIMEOUT)  e.err  = 1'b1;
        else if (rd)              e.data = ref_load(f3, alu, rdat);
        exp_q.push_back(e);

        in_valid = 1'b1; MemRead = rd; MemWr = wr; funct3 = f3; ALU_Out = alu; rd2 = wd;
        bus_if.bus_ack   = 1'($urandom_range(0, 1));  // stray ack in IDLE
        bus_if.bus_rdata = $urandom;
        @(posedge clk); #1;
        in_valid = 1'b0; MemRead = 1'b0; MemWr = 1'b0; bus_if.bus_ack = 1'b0;

        if (mem && legal) begin
            n         = size_bytes(f3);
            exp_be    = ((32'd1 << n) - 32'd1) << alu[1:0];
            exp_wdata = rd ? 32'h0 : (n == 1 ? wd[7:0] * 32'h0101_0101 :
                                      n == 2 ? wd[15:0] * 32'h0001_0001 : wd);
            check("bus_req", bus_if.bus_req, 1);
            check("bus_we", bus_if.bus_we, wr);
            check("bus_addr", bus_if.bus_addr, alu & 32'hFFFF_FFFC);
            check("bus_be", bus_if.bus_be, exp_be[3:0]);
            check("bus_wdata", bus_if.bus_wdata, exp_wdata);
            snap = {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_be};
            stable_err = 1'b0;
            quiet_err  = 1'b0;
            cyc = 0;
            while (stall === 1'b1 && cyc < TIMEOUT + 4) begin
                if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
                     bus_if.bus_be} !== snap) stable_err = 1'b1;
                if (out_valid !== 1'b0 || mem_err !== 1'b0 || read_data !== 32'h0) quiet_err = 1'b1;
                // upstream noise while stalled must be ignored
                in_valid = 1'b1; MemRead = 1'($urandom_range(0, 1)); ALU_Out = $urandom;
                funct3 = 3'($urandom_range(0, 7));
                if (cyc == lat) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rdat;
                end else begin
                    bus_if.bus_rdata = $urandom;
                end
                cyc++;
                @(posedge clk); #1;
                bus_if.bus_ack = 1'b0; in_valid = 1'b0; MemRead = 1'b0;
            end
            check("stall_cycles", cyc, (lat < TIMEOUT) ? lat + 1 : TIMEOUT);
            check("bus_stable", stable_err, 0);
            check("quiet_in_wait", quiet_err, 0);
            check("bus_req_drop", bus_if.bus_req, 0);
        end else if (mem) begin
            check("illegal_no_req", bus_if.bus_req, 0);
            check("illegal_no_stall", stall, 0);
        end
        check("resp_pulse", out_valid, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind, k, lat;

        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        #2 n_rst = 1'b1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_read_data", read_data, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_bus", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata,
                          bus_if.bus_be}, 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b0;

        // LB at 0x1003, sign-extended byte lane 3
        issue(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 0);
        // SH at 0x2002, ack in third wait cycle
        issue(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 2);
        // misaligned LW
        issue(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);
        // LHU timeout
        issue(1, 0, 3'b101, 32'h0000_4000, 32'h0, 32'h0, 1000);
        // ack in the last allowed cycle succeeds
        issue(1, 0, 3'b101, 32'h0000_4002, 32'h0, 32'h8765_4321, TIMEOUT - 1);
        // back-to-back non-memory
        issue(0, 0, 3'b000, 32'd5, 32'h0, 32'h0, 0);
        issue(0, 0, 3'b000, 32'd6, 32'h0, 32'h0, 0);
        check("nonmem_stall", stall, 0);
        // store with BU format and read+write both illegal
        issue(0, 1, 3'b100, 32'h0000_5000, 32'h1, 32'h0, 0);
        issue(1, 1, 3'b010, 32'h0000_5000, 32'h1, 32'h0, 0);

        // reset in the 2nd wait cycle of a load abandons it
        in_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b010; ALU_Out = 32'h0000_0100;
        @(posedge clk); #1;
        in_valid = 1'b0; MemRead = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_stall_pre", stall, 1);
        n_rst = 1'b1;
        #1;
        check("rst_mid_bus_req", bus_if.bus_req, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_out_valid", out_valid, 0);
        @(posedge clk); #1;
        n_rst = 1'b0;
        check("rst_release_idle", stall, 0);
        issue(1, 0, 3'b010, 32'h0, 32'h0, 32'hCAFE_F00D, 1);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            rd = (kind >= 3 && kind <= 5) || kind == 9;
            wr = (kind >= 6 && kind <= 8) || kind == 9;
            k  = $urandom_range(0, 9);
            if (k < 7) begin
                k  = $urandom_range(0, 4);
                f3 = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : (k == 2) ? 3'b010 :
                     (k == 3) ? 3'b100 : 3'b101;
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            k = $urandom_range(0, 19);
            if (k < 14)       lat = k % 4;
            else if (k < 17)  lat = TIMEOUT - 1;
            else if (k == 17) lat = TIMEOUT;
            else              lat = 2;
            issue(rd, wr, f3, a, $urandom, $urandom, lat);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end
endmodule
